// File: rtl/pc_fetch_unit_if.sv
// Bus bundle for the PC fetch unit: adder loop, instruction-memory
// handshake, decode output register, branch redirect and error flag.
// The master modport is the fetch unit; the slave modport is its environment.
interface pc_fetch_unit_if;
    // PC increment loop
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_in;

    // Branch redirect
    logic        branch_taken;
    logic [31:0] branch_target;

    // Instruction memory handshake
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;

    // Decode output register
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_ready;

    // Sticky timeout indication
    logic        fetch_err;

    modport master (
        output pc_out,
        input  pc_plus4_in,
        input  branch_taken,
        input  branch_target,
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data,
        output instr_valid,
        output instr_out,
        output instr_pc,
        input  instr_ready,
        output fetch_err
    );

    modport slave (
        input  pc_out,
        output pc_plus4_in,
        output branch_taken,
        output branch_target,
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data,
        input  instr_valid,
        input  instr_out,
        input  instr_pc,
        output instr_ready,
        input  fetch_err
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// LEGv8 program counter and instruction-fetch sequencer.
// Holds the PC, issues one instruction-memory request at a time, loads the
// fetched word into a valid/ready register for decode, commits the external
// +4 adder sum after each successful fetch, and handles branch redirects.
// A redirect that races an outstanding request parks the FSM in DROP so the
// stale response is swallowed before the new address is requested.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    pc_fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_FULL = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    // Word-align an address; instructions are always 4-byte aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    state_t      state_r;
    logic [31:0] pc_r;
    logic [7:0]  wait_cnt_r;
    logic        imem_req_r;
    logic [31:0] imem_addr_r;
    logic        instr_valid_r;
    logic [31:0] instr_out_r;
    logic [31:0] instr_pc_r;
    logic        fetch_err_r;

    logic [31:0] branch_pc_s;
    logic [31:0] req_pc_s;
    logic [7:0]  wait_inc_s;
    logic        timeout_s;
    logic        unused_ok_s;

    // The low target bits are deliberately discarded by the alignment.
    assign unused_ok_s = ^bus.branch_target[1:0];

    // Redirect address, the address any newly issued request uses, and the
    // timeout detection for the response wait counter.
    always_comb begin
        branch_pc_s = align_word(bus.branch_target);
        if (bus.branch_taken) begin
            req_pc_s = branch_pc_s;
        end else begin
            req_pc_s = pc_r;
        end
        wait_inc_s = wait_cnt_r + 8'd1;
        timeout_s  = (wait_inc_s == MAX_WAIT_C);
    end

    // Fetch FSM with all registered outputs; imem_req is a one-cycle strobe
    // raised on the edge that enters REQ, with imem_addr captured alongside.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            wait_cnt_r    <= 8'd0;
            imem_req_r    <= 1'b0;
            imem_addr_r   <= 32'h0000_0000;
            instr_valid_r <= 1'b0;
            instr_out_r   <= 32'h0000_0000;
            instr_pc_r    <= 32'h0000_0000;
            fetch_err_r   <= 1'b0;
        end else begin
            imem_req_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    state_r     <= ST_REQ;
                    imem_req_r  <= 1'b1;
                    imem_addr_r <= req_pc_s;
                end

                ST_REQ: begin
                    // The request is now in flight; a redirect must wait it out.
                    wait_cnt_r <= 8'd0;
                    if (bus.branch_taken) begin
                        state_r <= ST_DROP;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (bus.imem_ack) begin
                        if (bus.branch_taken) begin
                            // Response is for the old path: drop it, fetch target.
                            state_r     <= ST_REQ;
                            imem_req_r  <= 1'b1;
                            imem_addr_r <= req_pc_s;
                        end else begin
                            instr_out_r   <= bus.imem_data;
                            instr_pc_r    <= pc_r;
                            instr_valid_r <= 1'b1;
                            pc_r          <= bus.pc_plus4_in;
                            state_r       <= ST_FULL;
                        end
                    end else if (bus.branch_taken) begin
                        wait_cnt_r <= 8'd0;
                        state_r    <= ST_DROP;
                    end else if (timeout_s) begin
                        // Give up on this response and retry the same PC.
                        fetch_err_r <= 1'b1;
                        state_r     <= ST_REQ;
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= req_pc_s;
                    end else begin
                        wait_cnt_r <= wait_inc_s;
                    end
                end

                ST_FULL: begin
                    if (bus.instr_ready || bus.branch_taken) begin
                        instr_valid_r <= 1'b0;
                        state_r       <= ST_REQ;
                        imem_req_r    <= 1'b1;
                        imem_addr_r   <= req_pc_s;
                    end else begin
                        state_r <= ST_FULL;
                    end
                end

                ST_DROP: begin
                    if (bus.imem_ack) begin
                        state_r     <= ST_REQ;
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= req_pc_s;
                    end else if (timeout_s) begin
                        fetch_err_r <= 1'b1;
                        state_r     <= ST_REQ;
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= req_pc_s;
                    end else begin
                        wait_cnt_r <= wait_inc_s;
                    end
                end

                default: begin
                    state_r       <= ST_IDLE;
                    instr_valid_r <= 1'b0;
                end
            endcase

            // A redirect overrides the PC and empties the output register in
            // every state; it takes precedence over the per-state updates above.
            if (bus.branch_taken) begin
                pc_r          <= branch_pc_s;
                instr_valid_r <= 1'b0;
            end else begin
                pc_r <= pc_r;
                if (state_r == ST_WAIT && bus.imem_ack) begin
                    pc_r <= bus.pc_plus4_in;
                end else begin
                    pc_r <= pc_r;
                end
            end
        end
    end

    assign bus.pc_out      = pc_r;
    assign bus.imem_req    = imem_req_r;
    assign bus.imem_addr   = imem_addr_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.instr_out   = instr_out_r;
    assign bus.instr_pc    = instr_pc_r;
    assign bus.fetch_err   = fetch_err_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs are driven and outputs checked
// just after the falling clock edge; the +4 adder is modelled here.
module tb_pc_fetch_unit;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (15)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.pc_plus4_in = bus.pc_out + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0000_0000;
        bus.imem_ack      = 1'b0;
        bus.imem_data     = 32'h0000_0000;
        bus.instr_ready   = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk ("rst_pc",    bus.pc_out,      32'h0000_0000);
        chk1("rst_req",   bus.imem_req,    1'b0);
        chk ("rst_addr",  bus.imem_addr,   32'h0000_0000);
        chk1("rst_valid", bus.instr_valid, 1'b0);
        chk ("rst_out",   bus.instr_out,   32'h0000_0000);
        chk ("rst_ipc",   bus.instr_pc,    32'h0000_0000);
        chk1("rst_err",   bus.fetch_err,   1'b0);

        // Release: IDLE cycle first, request in the second cycle
        reset = 1'b0;
        chk1("idle_req", bus.imem_req, 1'b0);
        step();
        chk1("req0", bus.imem_req, 1'b1);
        chk ("addr0", bus.imem_addr, 32'h0000_0000);

        // Fetch 0 / 4 / 8 with ack one cycle after each request
        step();
        chk1("wait0_req", bus.imem_req, 1'b0);
        bus.imem_ack = 1'b1; bus.imem_data = 32'hA000_0000;
        step();
        bus.imem_ack = 1'b0;
        chk1("v0", bus.instr_valid, 1'b1);
        chk ("d0", bus.instr_out, 32'hA000_0000);
        chk ("ipc0", bus.instr_pc, 32'h0000_0000);
        chk ("pc4", bus.pc_out, 32'h0000_0004);
        step();
        chk1("v0_clr", bus.instr_valid, 1'b0);
        chk1("req1", bus.imem_req, 1'b1);
        chk ("addr1", bus.imem_addr, 32'h0000_0004);
        step();
        bus.imem_ack = 1'b1; bus.imem_data = 32'hA000_0004;
        step();
        bus.imem_ack = 1'b0;
        chk ("d1", bus.instr_out, 32'hA000_0004);
        chk ("ipc1", bus.instr_pc, 32'h0000_0004);
        step();
        chk ("addr2", bus.imem_addr, 32'h0000_0008);
        step();
        bus.imem_ack = 1'b1; bus.imem_data = 32'hA000_0008;
        step();
        bus.imem_ack = 1'b0;
        chk ("d2", bus.instr_out, 32'hA000_0008);
        chk ("ipc2", bus.instr_pc, 32'h0000_0008);

        // Backpressure: five stalled cycles hold everything steady
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk1("bp_valid", bus.instr_valid, 1'b1);
            chk ("bp_out", bus.instr_out, 32'hA000_0008);
            chk ("bp_pc", bus.pc_out, 32'h0000_000C);
            chk1("bp_req", bus.imem_req, 1'b0);
        end
        bus.instr_ready = 1'b1;
        step();
        chk1("bp_rel_req", bus.imem_req, 1'b1);
        chk ("bp_rel_addr", bus.imem_addr, 32'h0000_000C);

        // Branch in WAIT, stale ack two cycles later is dropped
        step();
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0103;
        step();
        bus.branch_taken = 1'b0;
        chk ("br_pc", bus.pc_out, 32'h0000_0100);
        chk1("br_valid", bus.instr_valid, 1'b0);
        step();
        chk1("drop_req", bus.imem_req, 1'b0);
        bus.imem_ack = 1'b1; bus.imem_data = 32'hDEAD_DEAD;
        step();
        bus.imem_ack = 1'b0;
        chk1("drop_valid", bus.instr_valid, 1'b0);
        chk1("drop_rereq", bus.imem_req, 1'b1);
        chk ("drop_addr", bus.imem_addr, 32'h0000_0100);

        // Branch coincident with ack in WAIT: immediate re-request
        step();
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0208;
        bus.imem_ack = 1'b1; bus.imem_data = 32'hBEEF_BEEF;
        step();
        bus.branch_taken = 1'b0; bus.imem_ack = 1'b0;
        chk1("brack_req", bus.imem_req, 1'b1);
        chk ("brack_addr", bus.imem_addr, 32'h0000_0208);
        chk1("brack_valid", bus.instr_valid, 1'b0);
        chk ("brack_pc", bus.pc_out, 32'h0000_0208);

        // Timeout: 14 silent WAIT cycles are tolerated, the 15th trips it
        step();
        repeat (14) step();
        chk1("to_err_pre", bus.fetch_err, 1'b0);
        chk1("to_req_pre", bus.imem_req, 1'b0);
        step();
        chk1("to_err", bus.fetch_err, 1'b1);
        chk1("to_retry", bus.imem_req, 1'b1);
        chk ("to_addr", bus.imem_addr, 32'h0000_0208);
        step();
        bus.imem_ack = 1'b1; bus.imem_data = 32'hC000_0208;
        step();
        bus.imem_ack = 1'b0;
        chk ("to_ipc", bus.instr_pc, 32'h0000_0208);
        chk ("to_data", bus.instr_out, 32'hC000_0208);
        chk1("to_sticky", bus.fetch_err, 1'b1);

        // Branch from FULL (with ready) to the top word, low bits masked
        bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFF;
        step();
        bus.branch_taken = 1'b0;
        chk1("wrap_req", bus.imem_req, 1'b1);
        chk ("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        chk1("wrap_valid0", bus.instr_valid, 1'b0);
        step();
        bus.imem_ack = 1'b1; bus.imem_data = 32'h1234_5678;
        step();
        bus.imem_ack = 1'b0;
        chk ("wrap_ipc", bus.instr_pc, 32'hFFFF_FFFC);
        chk ("wrap_pc", bus.pc_out, 32'h0000_0000);
        step();
        chk ("wrap_next", bus.imem_addr, 32'h0000_0000);

        // Reset in WAIT, then a late ack is ignored
        step();
        reset = 1'b1;
        #1;
        chk ("mrst_pc", bus.pc_out, 32'h0000_0000);
        chk1("mrst_valid", bus.instr_valid, 1'b0);
        chk ("mrst_out", bus.instr_out, 32'h0000_0000);
        chk ("mrst_ipc", bus.instr_pc, 32'h0000_0000);
        chk1("mrst_err", bus.fetch_err, 1'b0);
        chk1("mrst_req", bus.imem_req, 1'b0);
        step();
        reset = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_data = 32'hFACE_FACE;
        step();
        chk1("late_valid", bus.instr_valid, 1'b0);
        chk1("late_req", bus.imem_req, 1'b1);
        chk ("late_addr", bus.imem_addr, 32'h0000_0000);
        step();
        bus.imem_ack = 1'b0;
        chk1("late_valid2", bus.instr_valid, 1'b0);
        chk ("late_out", bus.instr_out, 32'h0000_0000);
        chk1("late_err", bus.fetch_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter register and instruction-fetch sequencer for the LEGv8 datapath.
- It is the other end of the PC-increment path. It drives the current PC into the constant-+4 adder, receives the adder's 32-bit sum back, and commits that sum as the next PC after each successful fetch.
- It runs a single-outstanding request/acknowledge handshake to instruction memory.
- It presents each fetched instruction to decode through a valid/ready output register, and supports branch redirect with flush.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- MAX_WAIT, 15, number of WAIT cycles without imem_ack before a timeout (range 1..255).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pc_out  output  32  current PC; feeds the +4 adder's b_in.
- pc_plus4_in  input  32  +4 adder sum; combinational function of pc_out.
- branch_taken  input  1  one-cycle redirect request.
- branch_target  input  32  redirect address; bits [1:0] are ignored and forced to 0.
- imem_req  output  1  instruction memory request strobe, one cycle wide.
- imem_addr  output  32  request address, valid while imem_req is high.
- imem_ack  input  1  memory response strobe, one cycle wide.
- imem_data  input  32  instruction word, valid while imem_ack is high.
- instr_valid  output  1  instruction available to decode.
- instr_out  output  32  fetched instruction.
- instr_pc  output  32  address of instr_out.
- instr_ready  input  1  decode accepts; a transfer occurs when instr_valid && instr_ready.
- fetch_err  output  1  sticky timeout flag.

Behaviour:
- Reset: asynchronous and active-high. While reset is high:
  - pc = RESET_PC, so pc_out = RESET_PC.
  - imem_req, imem_addr, instr_valid, instr_out, instr_pc and fetch_err are all 0.
  - The FSM is in IDLE and the wait counter is 0.
  - Asserting reset mid-operation abandons any outstanding request; an imem_ack arriving afterwards is ignored.
- pc_out is always the pc register, never the adder sum.
- FSM states: IDLE, REQ, WAIT, FULL, DROP.
- IDLE: lasts one cycle after reset release, then goes to REQ.
- REQ:
  - imem_req = 1 and imem_addr = pc for exactly this cycle.
  - Next state is WAIT and the wait counter is cleared.
- WAIT: imem_req = 0. On imem_ack:
  - instr_out <= imem_data, instr_pc <= pc, instr_valid <= 1.
  - pc <= pc_plus4_in.
  - Go to FULL.
- WAIT without ack: the counter increments. When it reaches MAX_WAIT, fetch_err <= 1 and the FSM goes to REQ to retry the same pc.
- Latency: the first imem_req is high in the 2nd cycle after reset release. In the best case instr_valid rises on the edge of the ack cycle.
- FULL:
  - instr_valid holds, and instr_out/instr_pc stay stable until the transfer.
  - On transfer, instr_valid <= 0 and go to REQ.
  - Sustained best-case throughput is one instruction per 3 cycles.
- Branch (branch_taken = 1), in any state, on the edge:
  - pc <= {branch_target[31:2], 2'b00} and instr_valid <= 0.
  - From IDLE or FULL: go to REQ. In FULL with instr_ready also high that cycle, the transfer still counts as completed.
  - From WAIT with imem_ack in the same cycle: the data is discarded, pc takes the target (not +4), go to REQ.
  - From WAIT without ack, or from REQ: a request is outstanding, so go to DROP.
- DROP:
  - imem_req = 0. On imem_ack the data is discarded and the FSM goes to REQ.
  - The timeout also applies here: at MAX_WAIT, set fetch_err and go to REQ.
  - A further branch while in DROP only updates pc.
- imem_ack seen in IDLE, REQ or FULL is ignored.
- Wrap-around: pc = 32'hFFFFFFFC fetches, then pc becomes 0, taken as supplied by pc_plus4_in with no special case.
- fetch_err is cleared only by reset.

Test Plan:
- Reset with RESET_PC=0, memory acking 1 cycle after each req, instr_ready=1 → imem_addr sequence 0, 4, 8; instr_pc 0/4/8 with matching data; first imem_req high in 2nd cycle after reset release.
- Backpressure: instr_ready=0 for 5 cycles after valid → instr_valid, instr_out and pc_out stable; no imem_req until the transfer.
- Branch to 32'h00000103 while in WAIT, ack 2 cycles later → that ack's data is dropped, instr_valid stays 0, next imem_addr = 32'h00000100.
- Branch coincident with ack in WAIT → data discarded, next imem_addr = branch target, no DROP stall.
- No ack for MAX_WAIT=15 cycles → fetch_err=1 from the 15th cycle, REQ retried at the same address; fetch_err stays 1 after later success; reset clears it.
- pc=32'hFFFFFFFC fetch → instr_pc=32'hFFFFFFFC, next imem_addr=0; reset asserted in WAIT then a late ack → outputs remain at reset values.
